// File: rtl/rand_target_picker.sv
// rand_target_picker: turns the free-running LFSR byte into a bounded target
// index 0..NUM_TARGETS-1. The byte is reduced by repeated subtraction, one
// subtraction per clock. When enabled, the stage avoids giving the same target
// twice in a row: it resamples a limited number of times and then falls back to
// the next index.
module rand_target_picker #(
  parameter int NUM_TARGETS = 9,
  parameter int TW          = 4,
  parameter int NO_REPEAT   = 1,
  parameter int MAX_RETRY   = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [7:0]    rand_in,
  input  logic          req,
  output logic          busy,
  output logic          valid,
  output logic [TW-1:0] target
);

  localparam logic [7:0] NT   = 8'(NUM_TARGETS);
  localparam int         RW   = $clog2(MAX_RETRY + 2);
  localparam logic [RW-1:0] RMAX = RW'(MAX_RETRY);

  typedef enum logic [1:0] {IDLE, REDUCE, CHECK} state_t;

  state_t        state, state_n;
  logic [7:0]    work, work_n;
  logic [RW-1:0] retries, retries_n;
  logic [TW-1:0] prev, prev_n, target_n;
  logic          have_prev, have_prev_n;
  logic          busy_n, valid_n;
  logic          rep;
  logic [7:0]    result;

  // State and datapath registers; reset aborts any request in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      work      <= '0;
      retries   <= '0;
      prev      <= '0;
      have_prev <= 1'b0;
      target    <= '0;
      busy      <= 1'b0;
      valid     <= 1'b0;
    end else begin
      state     <= state_n;
      work      <= work_n;
      retries   <= retries_n;
      prev      <= prev_n;
      have_prev <= have_prev_n;
      target    <= target_n;
      busy      <= busy_n;
      valid     <= valid_n;
    end
  end

  // Next state: accept, reduce one step per cycle, then check for a repeat.
  always_comb begin
    state_n     = state;
    work_n      = work;
    retries_n   = retries;
    prev_n      = prev;
    have_prev_n = have_prev;
    target_n    = target;
    busy_n      = busy;
    valid_n     = 1'b0;
    rep         = (NO_REPEAT != 0) && have_prev && (work == 8'(prev));
    result      = work;

    case (state)
      IDLE: begin
        if (req) begin
          work_n    = rand_in;
          retries_n = '0;
          busy_n    = 1'b1;
          state_n   = REDUCE;
        end
      end
      REDUCE: begin
        // work >= NT before the subtract, so this cannot underflow
        if (work >= NT) work_n = work - NT;
        else            state_n = CHECK;
      end
      CHECK: begin
        if (rep && (retries < RMAX)) begin
          retries_n = retries + 1'b1;
          work_n    = rand_in;
          state_n   = REDUCE;
        end else begin
          // Retries are used up: step to the neighbouring index, wrapping at the top
          if (rep) result = (work == NT - 8'd1) ? 8'd0 : work + 8'd1;
          target_n    = TW'(result);
          prev_n      = TW'(result);
          have_prev_n = 1'b1;
          valid_n     = 1'b1;
          busy_n      = 1'b0;
          state_n     = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule
